alu_rr_scheduler: RTL and testbench

//  Shares one ALU instance (add/sub/mul/div/and/or/not, N-bit, NZCV flags) between two

---
 rtl/alu_sched_pkg.sv | 35 +++
 rtl/alu_rr_scheduler_if.sv | 26 ++
 rtl/alu_rr_scheduler_alu.sv | 53 +++++
 rtl/alu_rr_scheduler_arb.sv | 22 ++
 rtl/alu_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 251 +++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_NOT = 3'b110,
    OP_ILL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Cycles from accept to response valid for a given opcode.
  function automatic int op_lat(input alu_op_t op, input int mul_lat, input int div_lat);
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between two issue ports and the shared ALU scheduler.
interface alu_rr_scheduler_if #(parameter int N = 24);

  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [1:0][2:0]    req_op_i;
  logic [1:0][N-1:0]  req_a_i;
  logic [1:0][N-1:0]  req_b_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic               rsp_id_o;
  logic [N-1:0]       rsp_result_o;
  logic [3:0]         rsp_flags_o;
  logic               rsp_err_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );

endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// N-bit ALU with NZCV flags; SUB carry means no borrow, DIV by zero yields all ones.
module alu
  import alu_sched_pkg::*;
#(
  parameter int N = 24
) (
  input  alu_op_t      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  logic [N:0] sum;
  logic [N:0] prod;
  logic       c;
  logic       v;

  always_comb begin
    sum    = '0;
    prod   = '0;
    c      = 1'b0;
    v      = 1'b0;
    result = '0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[N-1:0];
        c      = sum[N];
        v      = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        result = sum[N-1:0];
        c      = sum[N];
        v      = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      OP_MUL: begin
        // Only bit N of the product is needed beyond the result (carry out).
        prod   = {1'b0, a} * {1'b0, b};
        result = prod[N-1:0];
        c      = prod[N];
      end
      OP_DIV:  result = (b == '0) ? '1 : a / b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
    flags = {result[N-1], (result == '0), c, v};
  end

endmodule

// File: rtl/alu_rr_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer moves past whoever was just served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between two requesters with round-robin arbitration and
// fixed multi-cycle windows for MUL/DIV.
//   state | meaning
//   IDLE  | no op in flight, arbitrate and accept
//   EXEC  | multi-cycle op running, down-counter active
//   DONE  | response valid, may accept next op when consumer is ready
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N       = 24,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input logic               clk,
  input logic               rst,
  alu_rr_scheduler_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  alu_op_t          op_q;
  logic [N-1:0]     a_q, b_q;
  logic             id_q;
  logic [N-1:0]     res_q;
  logic [3:0]       flg_q;
  logic             err_q;

  logic [1:0]       grant, ready;
  logic             take_en, acc_any, acc_id, exec_last;
  alu_op_t          acc_op;
  int               acc_lat;

  logic [N-1:0]     alu_res, view_res;
  logic [3:0]       alu_flg, view_flg;
  logic             view_err;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid_i),
    .advance (acc_any),
    .grant   (grant)
  );

  alu #(.N(N)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  assign take_en         = ~rst & ((state == IDLE) | ((state == DONE) & bus.rsp_ready_i));
  assign ready           = grant & {2{take_en}};
  assign bus.req_ready_o = ready;
  assign acc_any         = |(ready & bus.req_valid_i);
  assign acc_id          = ready[1];
  assign acc_op          = alu_op_t'(bus.req_op_i[acc_id]);
  assign acc_lat         = op_lat(acc_op, MUL_LAT, DIV_LAT);
  assign exec_last       = (state == EXEC) && (cnt == CNT_W'(1));

  always_comb begin
    view_err = (op_q == OP_ILL) || ((op_q == OP_DIV) && (b_q == '0));
    view_res = (op_q == OP_ILL) ? '0 : alu_res;
    view_flg = (op_q == OP_ILL) ? '0 : alu_flg;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc_any) state_nxt = (acc_lat == 1) ? DONE : EXEC;
      EXEC: if (exec_last) state_nxt = DONE;
      DONE: begin
        if (bus.rsp_ready_i) begin
          if (acc_any) state_nxt = (acc_lat == 1) ? DONE : EXEC;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops answer straight from the latched operands; long ops are
  // registered at the end of their window so the ALU path gets the full window.
  always_comb begin
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_id_o     = 1'b0;
    bus.rsp_result_o = '0;
    bus.rsp_flags_o  = '0;
    bus.rsp_err_o    = 1'b0;
    if (state == DONE) begin
      bus.rsp_valid_o = 1'b1;
      bus.rsp_id_o    = id_q;
      if (op_lat(op_q, MUL_LAT, DIV_LAT) == 1) begin
        bus.rsp_result_o = view_res;
        bus.rsp_flags_o  = view_flg;
        bus.rsp_err_o    = view_err;
      end else begin
        bus.rsp_result_o = res_q;
        bus.rsp_flags_o  = flg_q;
        bus.rsp_err_o    = err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else if (acc_any) begin
      op_q <= acc_op;
      a_q  <= bus.req_a_i[acc_id];
      b_q  <= bus.req_b_i[acc_id];
      id_q <= acc_id;
      cnt  <= CNT_W'(acc_lat - 1);
    end else if (state == EXEC) begin
      cnt <= cnt - CNT_W'(1);
      if (exec_last) begin
        res_q <= view_res;
        flg_q <= view_flg;
        err_q <= view_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed and randomized checks of alu_rr_scheduler against an arithmetic reference.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int     N       = 24;
  localparam int     MUL_LAT = 3;
  localparam int     DIV_LAT = 6;
  localparam longint M       = longint'(1) << N;
  localparam longint H       = M / 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.N(N)) bus ();

  alu_rr_scheduler #(.N(N), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= H) ? x - M : x;
  endfunction

  function automatic void ref_alu(input int op, input longint a, input longint b,
                                  output longint res, output logic [3:0] flg, output logic err);
    longint s;
    logic   c, v;
    c = 0; v = 0; err = 0; res = 0;
    case (op)
      0: begin s = a + b; res = s % M; c = (s >= M); s = sgn(a) + sgn(b); v = (s >= H) || (s < -H); end
      1: begin res = (a - b + M) % M; c = (a >= b); s = sgn(a) - sgn(b); v = (s >= H) || (s < -H); end
      2: begin s = a * b; res = s % M; c = ((s / M) % 2) == 1; end
      3: begin
        if (b == 0) begin res = M - 1; err = 1; end
        else res = a / b;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = (M - 1) - a;
      default: begin flg = 4'b0000; err = 1; res = 0; return; end
    endcase
    flg = {(res >= H), (res == 0), c, v};
  endfunction

  function automatic int ref_lat(input int op);
    return (op == 2) ? MUL_LAT : (op == 3) ? DIV_LAT : 1;
  endfunction

  // Issue one op on a port with rsp_ready high and check the response it earns.
  task automatic issue(input string tag, input int port, input int op,
                       input longint a, input longint b, input bit hold);
    longint     e_res;
    logic [3:0] e_flg;
    logic       e_err;
    int         waited, lat, other;
    ref_alu(op, a, b, e_res, e_flg, e_err);
    other = 1 - port;
    @(negedge clk);
    bus.req_valid_i[port] = 1'b1;
    bus.req_op_i[port]    = 3'(op);
    bus.req_a_i[port]     = N'(a);
    bus.req_b_i[port]     = N'(b);
    #1;
    waited = 0;
    while (bus.req_ready_o[port] !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk({tag, "_accept"}, bus.req_ready_o[port], 1);
    @(negedge clk);
    bus.req_valid_i[port] = 1'b0;
    if (hold) begin
      bus.req_valid_i[other] = 1'b1;
      bus.req_op_i[other]    = 3'(OP_ADD);
    end
    #1;
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 40) begin
      if (hold) chk({tag, "_busy_ready"}, bus.req_ready_o, 0);
      @(negedge clk); #1; lat++;
    end
    if (hold) bus.req_valid_i[other] = 1'b0;
    chk({tag, "_latency"}, lat, ref_lat(op));
    chk({tag, "_valid"},   bus.rsp_valid_o, 1);
    chk({tag, "_id"},      bus.rsp_id_o, port);
    chk({tag, "_result"},  bus.rsp_result_o, e_res);
    chk({tag, "_flags"},   bus.rsp_flags_o, e_flg);
    chk({tag, "_err"},     bus.rsp_err_o, e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint     e_res, a0, b0, a1, b1, e_res2;
    logic [3:0] e_flg, e_flg2;
    logic       e_err, e_err2;
    int         seen;

    rst = 1'b1;
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 2'b11;
    for (int p = 0; p < 2; p++) begin
      bus.req_op_i[p] = 3'(OP_SUB);
      bus.req_a_i[p]  = N'(10);
      bus.req_b_i[p]  = N'(4);
    end

    // Requests held through reset must not be accepted.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready",  bus.req_ready_o, 0);
    chk("reset_valid",  bus.rsp_valid_o, 0);
    chk("reset_result", bus.rsp_result_o, 0);
    chk("reset_flags",  bus.rsp_flags_o, 0);
    chk("reset_err",    bus.rsp_err_o, 0);
    chk("reset_id",     bus.rsp_id_o, 0);

    // Both requesters valid every cycle: grants alternate starting at 0.
    ref_alu(int'(OP_SUB), 10, 4, e_res, e_flg, e_err);
    rst = 1'b0;
    #1;
    chk("rr_first_grant", bus.req_ready_o, 2'b01);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      chk("rr_valid",  bus.rsp_valid_o, 1);
      chk("rr_id",     bus.rsp_id_o, (i - 1) % 2);
      chk("rr_result", bus.rsp_result_o, e_res);
      if (i < 4) chk("rr_grant", bus.req_ready_o, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    bus.req_valid_i = 2'b00;

    issue("add_5_3", 0, int'(OP_ADD), 5, 3, 1'b0);
    issue("mul_carry", 1, int'(OP_MUL), 64'h1000, 64'h1000, 1'b1);
    chk("mul_carry_c", bus.rsp_flags_o[FLAG_C], 1);
    issue("div_zero", 0, int'(OP_DIV), 9, 0, 1'b0);
    issue("illegal", 1, int'(OP_ILL), 64'h123456, 64'h0000ff, 1'b0);
    issue("div_100_7", 1, int'(OP_DIV), 100, 7, 1'b1);

    // Backpressure: response held, nothing accepted, accept on rsp_ready rise.
    a0 = longint'($urandom_range(0, 32'(M - 1)));
    b0 = longint'($urandom_range(0, 32'(M - 1)));
    a1 = longint'($urandom_range(0, 32'(M - 1)));
    b1 = longint'($urandom_range(0, 32'(M - 1)));
    ref_alu(int'(OP_ADD), a0, b0, e_res, e_flg, e_err);
    ref_alu(int'(OP_OR), a1, b1, e_res2, e_flg2, e_err2);
    @(negedge clk);
    bus.rsp_ready_i    = 1'b0;
    bus.req_valid_i[0] = 1'b1;
    bus.req_op_i[0]    = 3'(OP_ADD);
    bus.req_a_i[0]     = N'(a0);
    bus.req_b_i[0]     = N'(b0);
    #1;
    chk("bp_accept", bus.req_ready_o[0], 1);
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    bus.req_valid_i[1] = 1'b1;
    bus.req_op_i[1]    = 3'(OP_OR);
    bus.req_a_i[1]     = N'(a1);
    bus.req_b_i[1]     = N'(b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  bus.rsp_valid_o, 1);
      chk("bp_result", bus.rsp_result_o, e_res);
      chk("bp_flags",  bus.rsp_flags_o, e_flg);
      chk("bp_err",    bus.rsp_err_o, e_err);
      chk("bp_id",     bus.rsp_id_o, 0);
      chk("bp_ready",  bus.req_ready_o, 0);
      @(negedge clk); #1;
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready_o, 2'b10);
    @(negedge clk);
    bus.req_valid_i[1] = 1'b0;
    #1;
    chk("bp_next_valid",  bus.rsp_valid_o, 1);
    chk("bp_next_id",     bus.rsp_id_o, 1);
    chk("bp_next_result", bus.rsp_result_o, e_res2);
    chk("bp_next_flags",  bus.rsp_flags_o, e_flg2);

    // Reset two cycles into a DIV window discards the op.
    @(negedge clk);
    bus.req_valid_i[0] = 1'b1;
    bus.req_op_i[0]    = 3'(OP_DIV);
    bus.req_a_i[0]     = N'(100);
    bus.req_b_i[0]     = N'(7);
    #1;
    chk("rstx_accept", bus.req_ready_o[0], 1);
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    #1;
    chk("rstx_busy", bus.rsp_valid_o, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i[0] = 1'b1;
    bus.req_op_i[0]    = 3'(OP_ADD);
    #1;
    chk("rstx_ready_in_reset", bus.req_ready_o, 0);
    @(negedge clk); #1;
    chk("rstx_valid",  bus.rsp_valid_o, 0);
    chk("rstx_result", bus.rsp_result_o, 0);
    chk("rstx_flags",  bus.rsp_flags_o, 0);
    chk("rstx_err",    bus.rsp_err_o, 0);
    chk("rstx_id",     bus.rsp_id_o, 0);
    chk("rstx_ready",  bus.req_ready_o, 0);
    rst = 1'b0;
    #1;
    chk("rstx_idle_ready", bus.req_ready_o, 2'b01);
    bus.req_valid_i[0] = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.rsp_valid_o === 1'b1) seen++;
    end
    chk("rstx_no_response", seen, 0);

    // Randomized ops across both ports.
    for (int i = 0; i < 24; i++) begin
      int     port, op;
      longint ra, rb;
      port = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 7));
      ra   = longint'($urandom_range(0, 32'(M - 1)));
      rb   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 3))
                                          : longint'($urandom_range(0, 32'(M - 1)));
      issue("rand", port, op, ra, rb, 1'b1);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
